// File: rtl/host_output_transmit_pkg.sv
// Shared constants for the host output transmit path: widths, line field offsets, FSM encoding.
package host_output_transmit_pkg;
  localparam int DESC_W     = 13;
  localparam int BUFID_W    = 9;
  localparam int LINE_W     = 7;
  localparam int ADDR_W     = BUFID_W + LINE_W;
  localparam int RD_LAT_DEF = 2;
  localparam int RD_LAT_MAX = 4;
  localparam int LINE_DW    = 134;
  localparam int HEAD_B     = 133;
  localparam int TAIL_B     = 132;
  localparam int INV_LO     = 128;

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    READ_S    = 2'd1,
    DRAIN_S   = 2'd2,
    RELEASE_S = 2'd3
  } state_t;
endpackage

// File: rtl/host_output_transmit_if.sv
// Scheduler / packet buffer / host FIFO / free pool signals of the transmit block.
// HOST_TX_STAT_EN adds the packet and descriptor-error counters.
interface host_output_transmit_if;
  import host_output_transmit_pkg::*;
  logic [DESC_W-1:0]  descriptor;
  logic               descriptor_wr;
  logic               host_outport_free;
  logic [ADDR_W-1:0]  pkt_raddr;
  logic               pkt_rd;
  logic [LINE_DW-1:0] pkt_rdata;
  logic [LINE_DW-1:0] host_data;
  logic               host_data_wr;
  logic               host_fifo_almost_full;
  logic [BUFID_W-1:0] bufid_free;
  logic               bufid_free_wr;
  logic               desc_err;
  logic [1:0]         hot_state;
`ifdef HOST_TX_STAT_EN
  logic [31:0]        tx_pkt_cnt;
  logic [31:0]        desc_err_cnt;
`endif

  modport master (
    output descriptor, descriptor_wr, pkt_rdata, host_fifo_almost_full,
`ifdef HOST_TX_STAT_EN
    input  tx_pkt_cnt, desc_err_cnt,
`endif
    input  host_outport_free, pkt_raddr, pkt_rd, host_data, host_data_wr,
    input  bufid_free, bufid_free_wr, desc_err, hot_state
  );

  modport slave (
    input  descriptor, descriptor_wr, pkt_rdata, host_fifo_almost_full,
`ifdef HOST_TX_STAT_EN
    output tx_pkt_cnt, desc_err_cnt,
`endif
    output host_outport_free, pkt_raddr, pkt_rd, host_data, host_data_wr,
    output bufid_free, bufid_free_wr, desc_err, hot_state
  );
endinterface

// File: rtl/host_output_transmit_rd_delay.sv
// Valid shift register matching packet-buffer read latency; each stage also carries a
// forced-last marker. Flush drops every in-flight entry.
module host_rd_delay_line #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_vld,
  input  logic in_last,
  output logic out_vld,
  output logic out_last,
  output logic empty
);
  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] last_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      last_pipe[1] <= in_last;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_last = last_pipe[STAGES];
  assign empty    = ~|vld_pipe;
endmodule

// File: rtl/host_output_transmit.sv
// Streams one packet per descriptor from the packet buffer to the host FIFO, then frees the bufid.
// HOST_TX_STAT_EN adds transmitted-packet and descriptor-error counters.
module host_output_transmit
  import host_output_transmit_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  host_output_transmit_if.slave bus
);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;

  state_t             state;
  logic [BUFID_W-1:0] bufid;
  logic [LINE_W-1:0]  line;
  logic               last_iss;
  logic               free;
  logic               free_wr;
  logic [BUFID_W-1:0] free_id;
  logic               err;
  logic               issue;
  logic               ret_vld;
  logic               ret_last;
  logic               ret_tail;
  logic               pipe_empty;
  logic               host_wr;
  logic               unused_desc;

  assign unused_desc = ^bus.descriptor[DESC_W-1:BUFID_W];

  assign issue    = (state == READ_S) && !bus.host_fifo_almost_full && !last_iss;
  assign host_wr  = ret_vld && (state == READ_S);
  // The returning tail also flushes the speculative reads still in flight behind it.
  assign ret_tail = host_wr && (bus.pkt_rdata[TAIL_B] || ret_last);

  host_rd_delay_line #(.STAGES(RD_LAT)) u_rd_delay (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (ret_tail),
    .in_vld   (issue),
    .in_last  (issue && (line == LINE_MAX)),
    .out_vld  (ret_vld),
    .out_last (ret_last),
    .empty    (pipe_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE_S;
      bufid    <= '0;
      line     <= '0;
      last_iss <= 1'b0;
      free     <= 1'b0;
      free_wr  <= 1'b0;
      free_id  <= '0;
      err      <= 1'b0;
    end else begin
      free_wr <= 1'b0;
      free_id <= '0;
      err     <= bus.descriptor_wr && (state != IDLE_S);
      case (state)
        IDLE_S: begin
          free <= 1'b1;
          if (bus.descriptor_wr) begin
            bufid    <= bus.descriptor[BUFID_W-1:0];
            line     <= '0;
            last_iss <= 1'b0;
            free     <= 1'b0;
            state    <= READ_S;
          end
        end
        READ_S: begin
          if (issue) begin
            line <= line + 1'b1;
            if (line == LINE_MAX) last_iss <= 1'b1;
          end
          if (ret_tail) state <= DRAIN_S;
        end
        DRAIN_S: begin
          if (pipe_empty) begin
            free_wr <= 1'b1;
            free_id <= bufid;
            state   <= RELEASE_S;
          end
        end
        RELEASE_S: begin
          free  <= 1'b1;
          state <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  assign bus.host_outport_free = free;
  assign bus.pkt_rd            = issue;
  assign bus.pkt_raddr         = {bufid, line};
  assign bus.host_data_wr      = host_wr;
  // Overflow-terminated packets get their tail bit forced on the final line.
  assign bus.host_data         = host_wr ? {bus.pkt_rdata[LINE_DW-1:TAIL_B+1],
                                            bus.pkt_rdata[TAIL_B] | ret_last,
                                            bus.pkt_rdata[TAIL_B-1:0]} : '0;
  assign bus.bufid_free        = free_id;
  assign bus.bufid_free_wr     = free_wr;
  assign bus.desc_err          = err;
  assign bus.hot_state         = state;

`ifdef HOST_TX_STAT_EN
  logic [31:0] tx_cnt;
  logic [31:0] err_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (free_wr) tx_cnt  <= tx_cnt + 32'd1;
      if (err)     err_cnt <= err_cnt + 32'd1;
    end
  end

  assign bus.tx_pkt_cnt   = tx_cnt;
  assign bus.desc_err_cnt = err_cnt;
`endif
endmodule

// File: tb/tb_host_output_transmit.sv
// Directed bench for host_output_transmit with a packet-buffer model and line/bufid scoreboard.
module tb_host_output_transmit;
  import host_output_transmit_pkg::*;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  host_output_transmit_if bus();
  host_output_transmit #(.RD_LAT(L)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt, wr_cnt, rel_cnt, af_rd, first_rd_cyc, first_wr_cyc, n, rel0;
  logic [ADDR_W-1:0] first_rd_addr;
  logic [LINE_DW-1:0] exp_q[$];
  logic [BUFID_W-1:0] bid_q[$];
  int tail_of [0:511];
  logic [ADDR_W-1:0] a_q [1:L];

  function automatic logic [LINE_DW-1:0] mk_line(input logic [BUFID_W-1:0] b, input int l, input int t);
    logic [LINE_DW-1:0] v;
    logic [6:0] lv;
    lv = l[6:0];
    v = '0;
    v[HEAD_B] = (l == 0);
    v[TAIL_B] = (l == t);
    v[INV_LO +: 4] = l[3:0];
    v[127:0] = {8{lv, b}};
    return v;
  endfunction

  // Packet buffer: fixed read latency L, contents derived from the address.
  always @(posedge clk) begin
    a_q[1] <= bus.pkt_raddr;
    for (int i = 2; i <= L; i++) a_q[i] <= a_q[i-1];
  end
  always_comb begin
    bus.pkt_rdata = mk_line(a_q[L][ADDR_W-1:LINE_W], int'(a_q[L][LINE_W-1:0]),
                            tail_of[a_q[L][ADDR_W-1:LINE_W]]);
  end

  task automatic check(input string tag, input logic [LINE_DW-1:0] obs, input logic [LINE_DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pkt_rd === 1'b1) begin
      rd_cnt++;
      if (first_rd_cyc < 0) begin
        first_rd_cyc = cyc;
        first_rd_addr = bus.pkt_raddr;
      end
      if (bus.host_fifo_almost_full) af_rd++;
    end
    if (bus.host_data_wr === 1'b1) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) check_i("extra_line", 1, 0);
      else check("line", bus.host_data, exp_q.pop_front());
    end
    if (bus.bufid_free_wr === 1'b1) begin
      rel_cnt++;
      if (bid_q.size() == 0) check_i("extra_release", 1, 0);
      else check_i("bufid_free", int'(bus.bufid_free), int'(bid_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_clear();
    rd_cnt = 0; wr_cnt = 0; af_rd = 0; first_rd_cyc = -1; first_wr_cyc = -1;
  endtask

  task automatic push_pkt(input logic [BUFID_W-1:0] b, input int t, input bit rel);
    logic [LINE_DW-1:0] v;
    tail_of[b] = t;
    for (int l = 0; l < 128; l++) begin
      v = mk_line(b, l, t);
      if (l == 127) v[TAIL_B] = 1'b1;
      exp_q.push_back(v);
      if (v[TAIL_B]) break;
    end
    if (rel) bid_q.push_back(b);
  endtask

  task automatic send_desc(input logic [DESC_W-1:0] d);
    bus.descriptor = d;
    bus.descriptor_wr = 1'b1;
    tick();
    bus.descriptor_wr = 1'b0;
  endtask

  task automatic wait_free(input int lim, output int cnt);
    cnt = 0;
    while (bus.host_outport_free !== 1'b1 && cnt < lim) begin
      tick();
      cnt++;
    end
    check_i("free_timeout", int'(bus.host_outport_free), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) tail_of[i] = 999;
    bus.descriptor = '0;
    bus.descriptor_wr = 1'b0;
    bus.host_fifo_almost_full = 1'b0;
    rel_cnt = 0;
    rec_clear();
    repeat (3) tick();
    check_i("rst_free", int'(bus.host_outport_free), 0);
    check_i("rst_pkt_rd", int'(bus.pkt_rd), 0);
    check_i("rst_data_wr", int'(bus.host_data_wr), 0);
    check_i("rst_bufid_wr", int'(bus.bufid_free_wr), 0);
    check_i("rst_state", int'(bus.hot_state), 0);
    rst_n = 1'b1;
    tick();
    check_i("free_after_rst", int'(bus.host_outport_free), 1);

    // 1-line packet, bufid 0x05
    rec_clear();
    push_pkt(9'h005, 0, 1'b1);
    send_desc(13'h0005);
    check_i("free_drop", int'(bus.host_outport_free), 0);
    wait_free(50, n);
    check_i("latency_1line", n + 1, L + 4);
    check_i("rd_addr", int'(first_rd_addr), int'({9'h005, 7'h00}));
    check_i("rd_to_wr", first_wr_cyc - first_rd_cyc, L);
    check_i("sb_empty1", exp_q.size() + bid_q.size(), 0);

    // 4-line packet, bufid 0x1FF, reserved descriptor bits set
    rec_clear();
    push_pkt(9'h1FF, 3, 1'b1);
    send_desc(13'h1FFF);
    wait_free(100, n);
    check_i("wr_cnt4", wr_cnt, 4);
    check_i("rd_cnt_spec", rd_cnt, 6);
    check_i("sb_empty2", exp_q.size() + bid_q.size(), 0);

    // almost_full held 5 cycles mid-packet
    rec_clear();
    push_pkt(9'h0A2, 9, 1'b1);
    send_desc(13'h00A2);
    repeat (2) tick();
    bus.host_fifo_almost_full = 1'b1;
    af_rd = 0;
    repeat (5) tick();
    bus.host_fifo_almost_full = 1'b0;
    check_i("rd_during_af", af_rd, 0);
    wait_free(100, n);
    check_i("wr_cnt_af", wr_cnt, 10);
    check_i("sb_empty3", exp_q.size() + bid_q.size(), 0);

    // descriptor strobe while busy
    rec_clear();
    push_pkt(9'h033, 6, 1'b1);
    send_desc(13'h0033);
    tick();
    check_i("state_read", int'(bus.hot_state), 1);
    send_desc(13'h0044);
    check_i("desc_err_pulse", int'(bus.desc_err), 1);
    tick();
    check_i("desc_err_low", int'(bus.desc_err), 0);
    wait_free(100, n);
    check_i("wr_cnt_err", wr_cnt, 7);
    check_i("sb_empty4", exp_q.size() + bid_q.size(), 0);
`ifdef HOST_TX_STAT_EN
    check_i("err_cnt", int'(bus.desc_err_cnt), 1);
    check_i("tx_cnt4", int'(bus.tx_pkt_cnt), 4);
`endif

    // no tail within 128 lines
    rec_clear();
    push_pkt(9'h100, 999, 1'b1);
    send_desc(13'h0100);
    wait_free(400, n);
    check_i("wr_cnt_ovf", wr_cnt, 128);
    check_i("rd_cnt_ovf", rd_cnt, 128);
    check_i("sb_empty5", exp_q.size() + bid_q.size(), 0);

    // reset mid-packet
    rec_clear();
    push_pkt(9'h0C3, 50, 1'b0);
    send_desc(13'h00C3);
    repeat (4) tick();
    rel0 = rel_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_i("mrst_free", int'(bus.host_outport_free), 0);
    check_i("mrst_pkt_rd", int'(bus.pkt_rd), 0);
    check_i("mrst_raddr", int'(bus.pkt_raddr), 0);
    check_i("mrst_data_wr", int'(bus.host_data_wr), 0);
    check("mrst_data", bus.host_data, '0);
    check_i("mrst_bufid_wr", int'(bus.bufid_free_wr), 0);
    check_i("mrst_state", int'(bus.hot_state), 0);
    exp_q.delete();
    tick();
    check_i("mrst_free_next", int'(bus.host_outport_free), 1);
    repeat (8) tick();
    check_i("mrst_no_release", rel_cnt, rel0);

    // recovery packet after reset
    rec_clear();
    push_pkt(9'h007, 1, 1'b1);
    send_desc(13'h0007);
    wait_free(100, n);
    check_i("wr_cnt_rec", wr_cnt, 2);
    check_i("sb_empty6", exp_q.size() + bid_q.size(), 0);
`ifdef HOST_TX_STAT_EN
    check_i("tx_cnt_rec", int'(bus.tx_pkt_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
